alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 64, operand/result width; only 64 is supported.
REQ-002 SHALL have port: Clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: ReqValid  input  1  requester presents BusA, BusB, ALUCtrl.
REQ-005 SHALL have port: ReqReady  output  1  unit can accept a request this cycle.
REQ-006 SHALL have ports: BusA  input  64  operand A; BusB  input  64  operand B; ALUCtrl  input  4  operation code.
REQ-007 SHALL have port: RespValid  output  1  BusW/Zero hold a completed result.
REQ-008 SHALL have port: RespReady  input  1  consumer takes the result this cycle.
REQ-009 SHALL have ports: BusW  output  64  registered result; Zero  output  1  registered (BusW == 0).
REQ-010 SHALL have port: Busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; ReqReady = 1 only in IDLE.
REQ-012 SHALL accept a request on a rising edge where ReqValid & ReqReady; operands captured at that edge; inputs ignored otherwise.
REQ-013 SHALL compute single-cycle ops: 0000 AND (A&B), 0001 OR (A|B), 0010 ADD (A+B, mod 2^64, carry discarded), 0110 SUB (A-B, mod 2^64), 0111 PASS (B).
REQ-014 SHALL, for single-cycle ops, load BusW/Zero at the accept edge and enter DONE; RespValid high in the cycle following accept (latency 1).
REQ-015 SHALL, for any undefined ALUCtrl code, return BusW = 0, Zero = 1 with latency 1.
REQ-016 SHALL hold BusW, Zero, RespValid stable in DONE until RespReady = 1; on that edge go to IDLE and drop RespValid.
REQ-017 SHALL NOT accept a new request in the cycle the response is consumed (ReqReady rises the cycle after).
REQ-018 SHALL compute Zero from the final registered BusW, never from an intermediate shift value.
REQ-019 SHALL ignore ReqValid while Busy; a dropped ReqValid mid-operation has no effect.

Reset
REQ-020 SHALL, on Reset assertion (any time, incl. mid-SHIFT or in DONE), immediately force state IDLE, BusW = 0, Zero = 0, RespValid = 0, Busy = 0, shift counter = 0; a pending result is discarded.
REQ-021 SHALL drive ReqReady = 0 while Reset is high and 1 in the first cycle after release.

Configuration
REQ-022 SHALL gate iterative shifts with macro ALU_SEQ_SHIFT_EN.
REQ-023 SHALL, with ALU_SEQ_SHIFT_EN defined, support 0011 LSL (A << B[5:0]) and 0100 LSR (logical A >> B[5:0]), one bit position per cycle in SHIFT.
REQ-024 SHALL, on shift accept, load working register with A and 6-bit counter with B[5:0]; if counter = 0, go straight to DONE with BusW = A (latency 1).
REQ-025 SHALL, in SHIFT, shift working register by 1 and decrement counter each cycle; on the cycle counter reaches 0, load BusW/Zero and enter DONE; total latency = 1 + B[5:0] cycles.
REQ-026 SHALL ignore BusB[63:6] for shifts.
REQ-027 SHALL, without ALU_SEQ_SHIFT_EN, contain no SHIFT state logic and treat 0011/0100 as undefined codes (REQ-015).

Verification
REQ-028 Bench: AND 0x4500,0x500 with RespReady = 1 -> RespValid one cycle after accept, BusW = 0x500, Zero = 0.
REQ-029 Bench: SUB 0x4321,0x4321 -> BusW = 0, Zero = 1; ADD 0xFFFFFFFFFFFFFFFF,0x1 -> BusW = 0, Zero = 1.
REQ-030 Bench: PASS 0x4321,0x1234 with RespReady held 0 for 5 cycles -> BusW = 0x1234 stable and RespValid = 1 throughout, ReqReady = 0; ReqReady = 1 the cycle after RespReady pulse.
REQ-031 Bench (shift enabled): LSL 0x1, B = 0x3F -> RespValid 64 cycles after accept, BusW = 0x8000000000000000; LSR 0x8000000000000000, B = 0x40 (shamt 0) -> latency 1, BusW unchanged.
REQ-032 Bench: Reset asserted mid-LSL (count 10 remaining) -> same-cycle BusW = 0, RespValid = 0, Busy = 0; next request OR 0x1200,0x34 returns 0x1234.
REQ-033 Bench (shift disabled): ALUCtrl = 0011, A = 0x5 -> latency 1, BusW = 0, Zero = 1.

Source files
------------

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - request/response 64-bit ALU; iterative LSL/LSR built only with ALU_SEQ_SHIFT_EN
module alu_seq_unit #(
    parameter int WIDTH = 64
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic [WIDTH-1:0] BusA,
    input  logic [WIDTH-1:0] BusB,
    input  logic [3:0]       ALUCtrl,
    output logic             RespValid,
    input  logic             RespReady,
    output logic [WIDTH-1:0] BusW,
    output logic             Zero,
    output logic             Busy
);

`ifdef ALU_SEQ_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_busw;
    logic             r_zero;
    logic             r_resp_valid;
    logic [WIDTH-1:0] w_result;

`ifdef ALU_SEQ_SHIFT_EN
    logic [WIDTH-1:0] r_work;
    logic [5:0]       r_cnt;
    logic             r_dir_right;
    logic             w_is_shift;
    logic [WIDTH-1:0] w_shifted;

    assign w_is_shift = (ALUCtrl == 4'b0011) || (ALUCtrl == 4'b0100);
    assign w_shifted  = r_dir_right ? (r_work >> 1) : (r_work << 1);
`endif

    // Undefined codes fall through to zero, which also makes Zero assert.
    always_comb begin
        w_result = '0;
        case (ALUCtrl)
            4'b0000: w_result = BusA & BusB;
            4'b0001: w_result = BusA | BusB;
            4'b0010: w_result = BusA + BusB;
            4'b0110: w_result = BusA - BusB;
            4'b0111: w_result = BusB;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_busw       <= '0;
            r_zero       <= 1'b0;
            r_resp_valid <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
            r_work       <= '0;
            r_cnt        <= 6'd0;
            r_dir_right  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ReqValid) begin
`ifdef ALU_SEQ_SHIFT_EN
                        if (w_is_shift) begin
                            r_work      <= BusA;
                            r_cnt       <= BusB[5:0];
                            r_dir_right <= (ALUCtrl == 4'b0100);
                            if (BusB[5:0] == 6'd0) begin
                                r_busw       <= BusA;
                                r_zero       <= (BusA == '0);
                                r_resp_valid <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_state <= S_SHIFT;
                            end
                        end else
`endif
                        begin
                            r_busw       <= w_result;
                            r_zero       <= (w_result == '0);
                            r_resp_valid <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
`ifdef ALU_SEQ_SHIFT_EN
                // Result and Zero are taken only from the final step, never mid-shift.
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_cnt  <= r_cnt - 6'd1;
                    if (r_cnt == 6'd1) begin
                        r_busw       <= w_shifted;
                        r_zero       <= (w_shifted == '0);
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    if (RespReady) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ReqReady  = (r_state == S_IDLE) && !Reset;
    assign Busy      = (r_state != S_IDLE);
    assign RespValid = r_resp_valid;
    assign BusW      = r_busw;
    assign Zero      = r_zero;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed scoreboard bench for alu_seq_unit
module tb_alu_seq_unit;

    logic        Clk;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;
    logic        RespValid;
    logic        RespReady;
    logic [63:0] BusW;
    logic        Zero;
    logic        Busy;

    int n_pass;
    int n_total;
    logic [64:0] exp_q[$];

    alu_seq_unit #(.WIDTH(64)) dut (
        .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .BusA(BusA), .BusB(BusB), .ALUCtrl(ALUCtrl), .RespValid(RespValid),
        .RespReady(RespReady), .BusW(BusW), .Zero(Zero), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp_w, input int exp_lat,
                         input int hold);
        logic [64:0] e;
        logic [63:0] held_w;
        int lat;
        exp_q.push_back({exp_w == 64'd0, exp_w});
        RespReady = (hold == 0);
        check({tag, " req_ready_idle"}, 64'(ReqReady), 64'd1);
        ReqValid = 1'b1;
        BusA = a;
        BusB = b;
        ALUCtrl = ctrl;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        BusA = {$urandom, $urandom};
        BusB = {$urandom, $urandom};
        ALUCtrl = 4'($urandom);
        lat = 1;
        while (!RespValid && lat < 200) begin
            @(posedge Clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 65'h0;
        check({tag, " busw"}, BusW, e[63:0]);
        check({tag, " zero"}, 64'(Zero), 64'(e[64]));
        held_w = BusW;
        for (int i = 0; i < hold; i++) begin
            ReqValid = 1'b1;
            BusA = {$urandom, $urandom};
            BusB = {$urandom, $urandom};
            ALUCtrl = 4'b0010;
            @(posedge Clk);
            #1;
            check({tag, " hold_valid"}, 64'(RespValid), 64'd1);
            check({tag, " hold_busw"}, BusW, held_w);
            check({tag, " hold_req_ready"}, 64'(ReqReady), 64'd0);
        end
        ReqValid = 1'b0;
        RespReady = 1'b1;
        check({tag, " req_ready_consume"}, 64'(ReqReady), 64'd0);
        @(posedge Clk);
        #1;
        RespReady = 1'b0;
        check({tag, " valid_dropped"}, 64'(RespValid), 64'd0);
        check({tag, " req_ready_after"}, 64'(ReqReady), 64'd1);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        Reset = 1'b1;
        ReqValid = 1'b0;
        RespReady = 1'b0;
        BusA = '0;
        BusB = '0;
        ALUCtrl = '0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst req_ready", 64'(ReqReady), 64'd0);
        check("rst resp_valid", 64'(RespValid), 64'd0);
        check("rst busw", BusW, 64'd0);
        check("rst zero", 64'(Zero), 64'd0);
        check("rst busy", 64'(Busy), 64'd0);
        Reset = 1'b0;
        #1;
        check("rst release req_ready", 64'(ReqReady), 64'd1);
        @(posedge Clk);
        #1;

        do_op("and", 4'b0000, 64'h4500, 64'h500, 64'h500, 1, 0);
        do_op("sub_eq", 4'b0110, 64'h4321, 64'h4321, 64'h0, 1, 0);
        do_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1, 0);
        do_op("sub_neg", 4'b0110, 64'h1, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        do_op("pass_hold", 4'b0111, 64'h4321, 64'h1234, 64'h1234, 1, 5);
        do_op("undef_f", 4'b1111, 64'hDEAD, 64'hBEEF, 64'h0, 1, 1);
`ifdef ALU_SEQ_SHIFT_EN
        do_op("lsl_63", 4'b0011, 64'h1, 64'h3F, 64'h8000_0000_0000_0000, 64, 0);
        do_op("lsr_0", 4'b0100, 64'h8000_0000_0000_0000, 64'h40, 64'h8000_0000_0000_0000, 1, 0);
        do_op("lsr_4", 4'b0100, 64'hF0, 64'hFFFF_FFFF_FFFF_FFC4, 64'hF, 5, 2);

        RespReady = 1'b0;
        ReqValid = 1'b1;
        BusA = 64'h1;
        BusB = 64'd20;
        ALUCtrl = 4'b0011;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        check("mid_shift busy", 64'(Busy), 64'd1);
`else
        do_op("undef_lsl", 4'b0011, 64'h5, 64'h1, 64'h0, 1, 0);
        do_op("undef_lsr", 4'b0100, 64'h5, 64'h1, 64'h0, 1, 0);

        RespReady = 1'b0;
        ReqValid = 1'b1;
        BusA = 64'h0;
        BusB = 64'h77;
        ALUCtrl = 4'b0111;
        @(posedge Clk);
        #1;
        ReqValid = 1'b0;
        check("pending resp_valid", 64'(RespValid), 64'd1);
`endif
        Reset = 1'b1;
        #1;
        check("abort busw", BusW, 64'd0);
        check("abort resp_valid", 64'(RespValid), 64'd0);
        check("abort busy", 64'(Busy), 64'd0);
        check("abort req_ready", 64'(ReqReady), 64'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        #1;
        check("abort release req_ready", 64'(ReqReady), 64'd1);
        @(posedge Clk);
        #1;
        do_op("or_after_rst", 4'b0001, 64'h1200, 64'h34, 64'h1234, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
